// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I sequencing controller:
// opcodes, FSM states, ALU codes and datapath mux selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Unified memory port handshake between the controller and memory.
interface riscv_multicycle_ctrl_if;
    logic mem_req;
    logic mem_write;
    logic mem_ready;

    modport master (output mem_req, output mem_write, input mem_ready);
    modport slave  (input mem_req, input mem_write, output mem_ready);
endinterface

// File: rtl/riscv_multicycle_ctrl_alu_decoder.sv
// Maps alu_op plus instruction fields to the ALU operation code.
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [6:0] op,
    output logic [2:0] alu_control
);

    logic unused_bits;
    assign unused_bits = ^{funct7[6], funct7[4:0], op[6], op[4:0]};

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type can subtract; addi ignores funct7
                    3'b000:  alu_control = (op[5] & funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I controller: sequences fetch/decode/execute/memory/writeback
// over one shared ALU and one memory port.
//  state      | meaning
//  FETCH      | read instruction, PC += 4
//  DECODE     | branch target into ALUOut, dispatch on op
//  MEMADR     | compute load/store address
//  MEMREAD    | load access
//  MEMWB      | write loaded data to register file
//  MEMWRITE   | store access
//  EXEC_R/I   | ALU operation
//  ALUWB      | write ALUOut to register file
//  BEQ        | compare, take branch on zero
//  JAL        | PC <- target, ALUOut <- PC+4
//  HALT       | unsupported opcode, wait for reset
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       rst,
    riscv_multicycle_ctrl_if.master mem,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic       mem_timeout,
    output logic [3:0] state
);

    localparam int CW = ($clog2(MEM_WAIT_MAX + 1) > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(MEM_WAIT_MAX);
    localparam logic [CW-1:0] LAST_CNT = CW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

    state_t        st;
    alu_op_t       alu_op;
    logic          pc_update;
    logic          branch;
    logic          in_mem_state;
    logic [CW-1:0] wait_cnt;

    assign state        = st;
    assign in_mem_state = (st == S_FETCH) || (st == S_MEMREAD) || (st == S_MEMWRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_FETCH;
            illegal     <= 1'b0;
            mem_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (st)
                S_FETCH:    if (mem.mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: st <= S_MEMADR;
                        OP_R:         st <= S_EXEC_R;
                        OP_I:         st <= S_EXEC_I;
                        OP_BEQ:       st <= S_BEQ;
                        OP_JAL:       st <= S_JAL;
                        default: begin
                            st      <= S_HALT;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:   st <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem.mem_ready) st <= S_MEMWB;
                S_MEMWB:    st <= S_FETCH;
                S_MEMWRITE: if (mem.mem_ready) st <= S_FETCH;
                S_EXEC_R:   st <= S_ALUWB;
                S_EXEC_I:   st <= S_ALUWB;
                S_ALUWB:    st <= S_FETCH;
                S_BEQ:      st <= S_FETCH;
                S_JAL:      st <= S_ALUWB;
                S_HALT:     st <= S_HALT;
                default:    st <= S_FETCH;
            endcase

            // Counter saturates at the limit so the pulse fires once per wait.
            mem_timeout <= 1'b0;
            if (in_mem_state && !mem.mem_ready) begin
                if (wait_cnt != MAX_CNT) begin
                    wait_cnt    <= wait_cnt + 1'b1;
                    mem_timeout <= (wait_cnt == LAST_CNT);
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_write = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RD2;
        result_src    = RES_ALUOUT;
        alu_op        = ALUOP_ADD;
        case (st)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_b   = SRCB_FOUR;
                result_src  = RES_ALURESULT;
                ir_write    = mem.mem_ready;
                pc_update   = mem.mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem.mem_req = 1'b1;
                adr_src     = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem.mem_req   = 1'b1;
                mem.mem_write = 1'b1;
                adr_src       = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_write = pc_update | (branch & zero);
    assign imm_src  = imm_src_of(op);

    riscv_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7      (funct7),
        .op          (op),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: directed scenarios plus random instruction
// streams checked against a step-list reference model.
module tb_riscv_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    localparam int WMAX = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = OP_LW;
    logic [2:0] funct3 = 3'b000;
    logic [6:0] funct7 = 7'b0;
    logic       zero = 1'b0;
    logic       adr_src, ir_write, pc_write, reg_write, illegal, mem_timeout;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int tests_run = 0;
    int fails = 0;

    riscv_multicycle_ctrl_if mif ();

    riscv_multicycle_ctrl #(.MEM_WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst), .mem(mif), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control),
        .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        state_t s;
        bit     rdy;
        bit     to;
    } step_t;

    step_t steps[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A memory step that sees w not-ready cycles; the timeout pulse shows
    // up the cycle after the WMAX-th consecutive wait.
    task automatic push_mem(input state_t s, input int w);
        for (int k = 0; k <= w; k++)
            steps.push_back('{s: s, rdy: (k == w), to: (k == WMAX && w >= WMAX)});
    endtask

    task automatic push_plain(input state_t s);
        steps.push_back('{s: s, rdy: 1'($urandom), to: 1'b0});
    endtask

    function automatic logic [1:0] imm_exp(input logic [6:0] o);
        if (o == OP_SW) return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] funct_alu_exp(input logic [6:0] o, input logic [2:0] f3,
                                                 input logic [6:0] f7);
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b000 && o == OP_R && f7[5]) return 3'b001;
        return 3'b000;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        mif.mem_ready = 1'b0;
        #3;
        tests_run++;
        if (state !== S_FETCH || mif.mem_req !== 1'b1 || illegal !== 1'b0 || mem_timeout !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: state=%0d req=%b ill=%b to=%b, want state=0 req=1 ill=0 to=0",
                     state, mif.mem_req, illegal, mem_timeout);
        end
        tests_run++;
        if ({alu_src_a, alu_src_b, result_src, reg_write, ir_write} !== 8'b00_10_10_0_0) begin
            fails++;
            $display("FAIL reset_selects: got %b want 0010100 0", {alu_src_a, alu_src_b, result_src, reg_write, ir_write});
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        op = OP_LW;
        mif.mem_ready = 1'b1;
        tick(); tick(); tick();
        mif.mem_ready = 1'b0;
        tick();
        tests_run++;
        if (state !== S_MEMREAD) begin
            fails++;
            $display("FAIL midrst_pre: state=%0d want %0d", state, S_MEMREAD);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (state !== S_FETCH || mif.mem_req !== 1'b1 || adr_src !== 1'b0 || reg_write !== 1'b0 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL midrst_memread: state=%0d req=%b adr=%b rw=%b ill=%b want 0 1 0 0 0",
                     state, mif.mem_req, adr_src, reg_write, illegal);
        end
        tick();
        rst = 1'b0;
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (state !== S_MEMWB || reg_write !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre_wb: state=%0d rw=%b want %0d 1", state, reg_write, S_MEMWB);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (state !== S_FETCH || reg_write !== 1'b0) begin
            fails++;
            $display("FAIL midrst_memwb: state=%0d rw=%b want 0 0", state, reg_write);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_lw();
        state_t seq[5];
        seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
        op = OP_LW;
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (state !== seq[i] || reg_write !== (i == 4)) begin
                fails++;
                $display("FAIL lw_cycle%0d: state=%0d rw=%b want %0d %b", i, state, reg_write, seq[i], (i == 4));
            end
            if (i == 4) begin
                tests_run++;
                if (result_src !== 2'b01) begin
                    fails++;
                    $display("FAIL lw_result_src: got %b want 01", result_src);
                end
            end
            tick();
        end
        tests_run++;
        if (state !== S_FETCH) begin
            fails++;
            $display("FAIL lw_return: state=%0d want 0", state);
        end
    endtask

    task automatic test_r_alu();
        logic [6:0] ops[4];
        logic [2:0] f3s[4];
        logic [6:0] f7s[4];
        logic [2:0] want[4];
        ops = '{OP_R, OP_R, OP_R, OP_I};
        f3s = '{3'b000, 3'b000, 3'b010, 3'b000};
        f7s = '{7'b0100000, 7'b0000000, 7'b0000000, 7'b0100000};
        want = '{3'b001, 3'b000, 3'b101, 3'b000};
        mif.mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            op = ops[c]; funct3 = f3s[c]; funct7 = f7s[c];
            tick(); tick();
            @(negedge clk);
            tests_run++;
            if (state !== ((c == 3) ? S_EXEC_I : S_EXEC_R) || alu_control !== want[c]) begin
                fails++;
                $display("FAIL alu_case%0d: state=%0d alu=%b want alu=%b", c, state, alu_control, want[c]);
            end
            tick();
            @(negedge clk);
            tests_run++;
            if (state !== S_ALUWB || reg_write !== 1'b1 || result_src !== 2'b00) begin
                fails++;
                $display("FAIL alu_wb%0d: state=%0d rw=%b res=%b", c, state, reg_write, result_src);
            end
            tick();
        end
    endtask

    task automatic test_beq();
        op = OP_BEQ;
        mif.mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = 1'b1;
            tick();
            @(negedge clk);
            tests_run++;
            if (state !== S_DECODE || pc_write !== 1'b0) begin
                fails++;
                $display("FAIL beq_decode: state=%0d pcw=%b want 1 0", state, pc_write);
            end
            tick();
            zero = 1'(z);
            @(negedge clk);
            tests_run++;
            if (state !== S_BEQ || pc_write !== 1'(z) || alu_control !== 3'b001) begin
                fails++;
                $display("FAIL beq_zero%0d: state=%0d pcw=%b alu=%b want pcw=%0d alu=001", z, state, pc_write, alu_control, z);
            end
            tick();
            tests_run++;
            if (state !== S_FETCH) begin
                fails++;
                $display("FAIL beq_return%0d: state=%0d want 0", z, state);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_sw_timeout();
        int pulses = 0;
        op = OP_SW;
        mif.mem_ready = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            mif.mem_ready = (i == 3);
            @(negedge clk);
            pulses += int'(mem_timeout);
            tests_run++;
            if (state !== S_MEMWRITE || mif.mem_write !== 1'b1 || mif.mem_req !== 1'b1) begin
                fails++;
                $display("FAIL sw_wait%0d: state=%0d wr=%b req=%b", i, state, mif.mem_write, mif.mem_req);
            end
            tick();
        end
        tests_run++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL sw_timeout_count: got %0d pulses want 1", pulses);
        end
        tests_run++;
        if (state !== S_FETCH || mem_timeout !== 1'b0) begin
            fails++;
            $display("FAIL sw_return: state=%0d to=%b want 0 0", state, mem_timeout);
        end
    endtask

    task automatic test_halt();
        op = 7'b1111111;
        mif.mem_ready = 1'b1;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            mif.mem_ready = 1'($urandom);
            @(negedge clk);
            tests_run++;
            if (state !== S_HALT || illegal !== 1'b1 || mif.mem_req !== 1'b0 || reg_write !== 1'b0 || pc_write !== 1'b0) begin
                fails++;
                $display("FAIL halt_cycle%0d: state=%0d ill=%b req=%b rw=%b pcw=%b", i, state, illegal, mif.mem_req, reg_write, pc_write);
            end
            tick();
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (state !== S_FETCH || illegal !== 1'b0) begin
            fails++;
            $display("FAIL halt_reset: state=%0d ill=%b want 0 0", state, illegal);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0] opl[6];
        logic [2:0] f3l[6];
        logic [22:0] got, exp;
        step_t st_e;
        int fw, mw;
        opl = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
        f3l = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b001, 3'b100};
        for (int n = 0; n < 60; n++) begin
            op = opl[$urandom_range(0, 5)];
            funct3 = f3l[$urandom_range(0, 5)];
            funct7 = 7'($urandom);
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            steps.delete();
            push_mem(S_FETCH, fw);
            push_plain(S_DECODE);
            if (op == OP_LW) begin
                push_plain(S_MEMADR); push_mem(S_MEMREAD, mw); push_plain(S_MEMWB);
            end else if (op == OP_SW) begin
                push_plain(S_MEMADR); push_mem(S_MEMWRITE, mw);
            end else if (op == OP_R) begin
                push_plain(S_EXEC_R); push_plain(S_ALUWB);
            end else if (op == OP_I) begin
                push_plain(S_EXEC_I); push_plain(S_ALUWB);
            end else if (op == OP_BEQ) begin
                push_plain(S_BEQ);
            end else begin
                push_plain(S_JAL); push_plain(S_ALUWB);
            end
            while (steps.size() > 0) begin
                st_e = steps.pop_front();
                mif.mem_ready = st_e.rdy;
                zero = 1'($urandom);
                @(negedge clk);
                exp[22] = (st_e.s == S_FETCH) || (st_e.s == S_MEMREAD) || (st_e.s == S_MEMWRITE);
                exp[21] = (st_e.s == S_MEMWRITE);
                exp[20] = (st_e.s == S_MEMREAD) || (st_e.s == S_MEMWRITE);
                exp[19] = (st_e.s == S_FETCH) && st_e.rdy;
                exp[18] = ((st_e.s == S_FETCH) && st_e.rdy) || (st_e.s == S_JAL) || ((st_e.s == S_BEQ) && zero);
                exp[17] = (st_e.s == S_MEMWB) || (st_e.s == S_ALUWB);
                exp[16:15] = (st_e.s == S_DECODE || st_e.s == S_JAL) ? 2'b01 :
                             (st_e.s == S_MEMADR || st_e.s == S_EXEC_R || st_e.s == S_EXEC_I || st_e.s == S_BEQ) ? 2'b10 : 2'b00;
                exp[14:13] = (st_e.s == S_FETCH || st_e.s == S_JAL) ? 2'b10 :
                             (st_e.s == S_DECODE || st_e.s == S_MEMADR || st_e.s == S_EXEC_I) ? 2'b01 : 2'b00;
                exp[12:11] = (st_e.s == S_FETCH) ? 2'b10 : (st_e.s == S_MEMWB) ? 2'b01 : 2'b00;
                exp[10:9] = imm_exp(op);
                exp[8:6] = (st_e.s == S_EXEC_R || st_e.s == S_EXEC_I) ? funct_alu_exp(op, funct3, funct7) :
                           (st_e.s == S_BEQ) ? 3'b001 : 3'b000;
                exp[5] = 1'b0;
                exp[4] = st_e.to;
                exp[3:0] = st_e.s;
                got = {mif.mem_req, mif.mem_write, adr_src, ir_write, pc_write, reg_write, alu_src_a,
                       alu_src_b, result_src, imm_src, alu_control, illegal, mem_timeout, state};
                tests_run++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL random_instr%0d op=%b: got %b want %b", n, op, got, exp);
                end
                tick();
            end
        end
        tests_run++;
        if (state !== S_FETCH) begin
            fails++;
            $display("FAIL random_end: state=%0d want 0", state);
        end
    endtask

    initial begin
        mif.mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_r_alu();
        test_beq();
        test_sw_timeout();
        test_random();
        test_reset_mid();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Sequencing controller for the multi-cycle RV32I core variant. It replaces combinational per-instruction control with an FSM that time-shares one ALU and one unified memory port across fetch, decode, execute, memory and writeback steps. It drives the datapath mux selects, register/IR/PC write enables and a req/ready memory handshake. Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.

Parameters:
MEM_WAIT_MAX, 0, if nonzero, cycles a memory state may wait for mem_ready before mem_timeout pulses; 0 disables the timeout.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous reset, active-high
op  input  7  IR[6:0]
funct3  input  3  IR[14:12]
funct7  input  7  IR[31:25]
zero  input  1  ALU zero flag, current cycle
mem_ready  input  1  memory completes the access this cycle
mem_req  output  1  memory access request
mem_write  output  1  store qualifier, valid with mem_req
adr_src  output  1  0 = PC, 1 = ALUOut register
ir_write  output  1  latch instruction and old PC
pc_write  output  1  PC enable: pc_update OR (branch AND zero)
reg_write  output  1  register-file write
alu_src_a  output  2  00 PC, 01 OldPC, 10 RD1
alu_src_b  output  2  00 RD2, 01 ImmExt, 10 constant 4
result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
imm_src  output  2  00 I, 01 S, 10 B, 11 J
alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal  output  1  sticky; unsupported opcode decoded
mem_timeout  output  1  one-cycle pulse on wait overrun
state  output  4  current state encoding, for debug

Behaviour:
- Reset (asynchronous, immediate): state = FETCH; illegal = 0; mem_timeout = 0. Reset applies mid-instruction at any point. Every output is a Moore function of state plus the listed inputs, so all outputs take their FETCH values during reset. No partial writes may issue after reset asserts.
- Default output value is 0 unless a state lists otherwise.
- imm_src decodes from op in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- alu_control comes from alu_op:
  - 00 gives add.
  - 01 gives sub.
  - 10 decodes funct3: 000 gives sub if op[5] & funct7[5], else add; 010 slt; 110 or; 111 and; other add.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write and pc_write equal mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE: a=01, b=01, alu_op=00 (branch target into ALUOut). Next state by op:
  - lw/sw go to MEMADR.
  - R goes to EXEC_R.
  - I-ALU goes to EXEC_I.
  - beq goes to BEQ.
  - jal goes to JAL.
  - Any other op goes to HALT.
- MEMADR: a=10, b=01, alu_op=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Go to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Wait for mem_ready, then go to FETCH.
- EXEC_R: a=10, b=00, alu_op=10. Go to ALUWB.
- EXEC_I: a=10, b=01, alu_op=10. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1. Go to FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, pc_write=zero. Go to FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. Go to ALUWB.
- HALT: illegal=1 (sticky), all enables 0, absorbing until rst.
- Latency with zero-wait memory:
  - lw: 5 cycles.
  - sw, R, I, jal: 4 cycles.
  - beq: 3 cycles.
  - Each mem_ready=0 cycle in a memory state adds 1 cycle.
- Timeout: a wait counter clears on entry to each memory state. If MEM_WAIT_MAX>0 and the count reaches MEM_WAIT_MAX with mem_ready still 0, mem_timeout pulses once. The FSM keeps waiting.
- mem_ready outside memory states is ignored.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - the state enum;
  - alu_control codes;
  - mux-select localparams.
- One sub-module, riscv_alu_decoder, performs the combinational alu_op/funct3/funct7/op to alu_control mapping.

Test Plan:
1. Reset during MEMREAD with mem_ready=0 -> state=FETCH the same cycle, mem_req=1, adr_src=0, reg_write=0, illegal=0.
2. op=0000011, mem_ready=1 always -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles); reg_write=1 only in cycle 5 with result_src=01.
3. op=0110011, funct3=000, funct7=0100000 -> EXEC_R asserts alu_control=001. With funct7=0000000 -> 000. With funct3=010 -> 101.
4. op=1100011, zero=1 -> pc_write=1 in BEQ. zero=0 -> pc_write=0. Both cases return to FETCH after 3 cycles.
5. op=0100011 with mem_ready held 0 for 3 cycles in MEMWRITE, MEM_WAIT_MAX=2 -> mem_write=1 throughout, exactly one mem_timeout pulse, FETCH after mem_ready.
6. op=1111111 -> HALT after DECODE, illegal=1, and mem_req=0 for 10 cycles until rst.
